// File: rtl/sar_ramp_conv_ctrl_if.sv
// Handshake and data bundle between the pin wrapper and the SAR/ramp
// conversion controller.
interface sar_ramp_conv_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mode;
  logic             comp_in;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             sat;

  modport master (
    output start, mode, comp_in,
    input  dac_code, busy, done, result, valid, sat
  );

  modport slave (
    input  start, mode, comp_in,
    output dac_code, busy, done, result, valid, sat
  );
endinterface

// File: rtl/sar_ramp_conv_ctrl.sv
// Conversion controller: drives a DAC code and resolves the comparator
// by successive approximation (mode 0) or a linear ramp (mode 1).
module sar_ramp_conv_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SETTLE      = 2,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  sar_ramp_conv_ctrl_if.slave bus
);
  localparam int WAIT_LOAD = SETTLE + SYNC_STAGES - 1;
  localparam int CNT_W     = $clog2(WAIT_LOAD + 1);
  localparam int IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIAL,
    S_WAIT,
    S_DECIDE,
    S_FINISH
  } state_t;

  state_t                 r_state;
  logic                   r_mode;
  logic [IDX_W-1:0]       r_idx;
  logic [CNT_W-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_acc;
  logic [WIDTH-1:0]       r_dac;
  logic [WIDTH-1:0]       r_result;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_valid;
  logic                   r_sat;
  logic [SYNC_STAGES-1:0] r_sync;

  logic                   w_comp_s;
  logic [WIDTH-1:0]       w_bit;
  logic [WIDTH-1:0]       w_sar_next;
  logic [WIDTH-1:0]       w_ramp_res;

  // One-hot mask of the SAR bit currently under trial.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_bit[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  assign w_comp_s   = r_sync[SYNC_STAGES-1];
  assign w_sar_next = w_comp_s ? r_dac : r_acc;
  // The ramp stops one step past the last passing code.
  assign w_ramp_res = (r_acc == '0) ? '0 : r_acc - WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.comp_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mode   <= 1'b0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_dac    <= '0;
      r_result <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
      r_sat    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode  <= bus.mode;
            r_valid <= 1'b0;
            r_sat   <= 1'b0;
            r_busy  <= 1'b1;
            r_acc   <= '0;
            r_idx   <= IDX_W'(WIDTH - 1);
            r_state <= S_TRIAL;
          end
        end
        S_TRIAL: begin
          r_dac   <= r_mode ? r_acc : (r_acc | w_bit);
          r_cnt   <= CNT_W'(WAIT_LOAD);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DECIDE;
          end
        end
        S_DECIDE: begin
          if (!r_mode) begin
            if (r_idx == '0) begin
              r_result <= w_sar_next;
              r_dac    <= w_sar_next;
              r_valid  <= 1'b1;
              r_done   <= 1'b1;
              r_state  <= S_FINISH;
            end else begin
              r_acc   <= w_sar_next;
              r_idx   <= r_idx - IDX_W'(1);
              r_state <= S_TRIAL;
            end
          end else if (!w_comp_s) begin
            r_result <= w_ramp_res;
            r_dac    <= w_ramp_res;
            r_valid  <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end else if (r_acc == ALL_ONES) begin
            // Comparator never fell: saturate instead of wrapping.
            r_result <= ALL_ONES;
            r_dac    <= ALL_ONES;
            r_sat    <= 1'b1;
            r_valid  <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end else begin
            r_acc   <= r_acc + WIDTH'(1);
            r_state <= S_TRIAL;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.dac_code = r_dac;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.valid    = r_valid;
  assign bus.sat      = r_sat;
endmodule

// File: tb/tb_sar_ramp_conv_ctrl.sv
// Self-checking bench for sar_ramp_conv_ctrl: vector table, corner-case
// sequences and randomized conversions against a search-based reference.
module tb_sar_ramp_conv_ctrl;
  localparam int WIDTH       = 8;
  localparam int SETTLE      = 2;
  localparam int SYNC_STAGES = 2;
  localparam int K           = SETTLE + SYNC_STAGES + 1;
  localparam int BOUND       = 3000;

  typedef struct {
    logic       mode;
    logic [7:0] vin;
    logic [7:0] exp_res;
    logic       exp_sat;
    int         exp_lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] vin = 8'd0;
  logic       async_mode = 1'b0;
  logic       comp_async = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] trial_codes[$];
  vec_t       vecs[6];

  sar_ramp_conv_ctrl_if #(.WIDTH(WIDTH)) bus ();

  sar_ramp_conv_ctrl #(
    .WIDTH(WIDTH),
    .SETTLE(SETTLE),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Comparator: ideal, or glitching at a random phase before settling.
  assign bus.comp_in = async_mode ? comp_async : (vin >= bus.dac_code);

  initial begin
    forever begin
      @(bus.dac_code or vin);
      #($urandom_range(1, 3));
      comp_async = ~comp_async;
      #($urandom_range(1, 3));
      comp_async = (vin >= bus.dac_code);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Largest passing code; ramp stops at the first failing code or saturates.
  function automatic void ref_model(input logic m, input logic [7:0] v,
                                    output logic [7:0] res, output logic s, output int lat);
    int best;
    int stop;
    best = 0;
    stop = -1;
    for (int c = 0; c < 256; c++) if (int'(v) >= c) best = c;
    res = 8'(best);
    if (!m) begin
      s   = 1'b0;
      lat = WIDTH * K;
    end else begin
      for (int c = 0; c < 256; c++) if (stop < 0 && !(int'(v) >= c)) stop = c;
      s = (stop < 0);
      if (stop < 0) stop = 255;
      lat = (stop + 1) * K;
    end
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < BOUND) begin
      tick();
      n++;
    end
    check("wait_idle", bus.busy, 0);
  endtask

  task automatic run_conv(input string name, input logic m, input logic [7:0] v,
                          input int pulse_at, input logic [7:0] exp_res,
                          input logic exp_sat, input int exp_lat);
    int n;
    bit seen;
    wait_idle();
    vin = v;
    bus.mode = m;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({name, "_busy_up"}, bus.busy, 1);
    check({name, "_valid_clr"}, bus.valid, 0);
    trial_codes.delete();
    n = 0;
    seen = 1'b0;
    while (!seen && n < BOUND) begin
      tick();
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
      else if ((n - 1) % K == 0) trial_codes.push_back(bus.dac_code);
      if (n == pulse_at) begin
        bus.start = 1'b1;
        bus.mode = ~m;
      end else if (n == pulse_at + 1) begin
        bus.start = 1'b0;
      end
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_latency"}, n, exp_lat);
    check({name, "_result"}, bus.result, exp_res);
    check({name, "_sat"}, bus.sat, exp_sat);
    check({name, "_valid"}, bus.valid, 1);
    check({name, "_busy_at_done"}, bus.busy, 1);
    $display("conv %s mode=%0d vin=%0d result=%0d sat=%0d cycles=%0d",
             name, m, v, bus.result, bus.sat, n);
    tick();
    check({name, "_done_width"}, bus.done, 0);
    check({name, "_busy_fall"}, bus.busy, 0);
  endtask

  initial begin
    logic [7:0] sar_exp[8];
    logic [7:0] r_res;
    logic       r_sat;
    int         r_lat;
    int         ndone;
    int         nbusy;
    int         n;
    logic       m;
    logic [7:0] v;

    vecs[0] = '{1'b0, 8'd100, 8'd100, 1'b0, 40};
    vecs[1] = '{1'b1, 8'd3,   8'd3,   1'b0, 25};
    vecs[2] = '{1'b1, 8'd255, 8'd255, 1'b1, 1280};
    vecs[3] = '{1'b0, 8'd255, 8'd255, 1'b0, 40};
    vecs[4] = '{1'b0, 8'd0,   8'd0,   1'b0, 40};
    vecs[5] = '{1'b1, 8'd0,   8'd0,   1'b0, 10};
    sar_exp = '{8'd128, 8'd64, 8'd96, 8'd112, 8'd104, 8'd100, 8'd102, 8'd101};

    bus.start = 1'b0;
    bus.mode = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {bus.dac_code, bus.busy, bus.done, bus.result, bus.valid, bus.sat}, 0);
    rst_n = 1'b1;
    tick();
    check("idle_after_reset", {bus.busy, bus.done, bus.valid}, 0);

    for (int i = 0; i < 6; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].mode, vecs[i].vin, -1,
               vecs[i].exp_res, vecs[i].exp_sat, vecs[i].exp_lat);
    end

    run_conv("sar100_codes", 1'b0, 8'd100, -1, 8'd100, 1'b0, 40);
    check("sar100_ntrials", trial_codes.size(), 8);
    for (int t = 0; t < 8; t++) begin
      if (t < trial_codes.size()) check($sformatf("sar100_code%0d", t), trial_codes[t], sar_exp[t]);
    end

    run_conv("ramp3_codes", 1'b1, 8'd3, -1, 8'd3, 1'b0, 25);
    check("ramp3_ntrials", trial_codes.size(), 5);
    for (int t = 0; t < 5; t++) begin
      if (t < trial_codes.size()) check($sformatf("ramp3_code%0d", t), trial_codes[t], t);
    end

    run_conv("sar0_start_while_busy", 1'b0, 8'd0, 17, 8'd0, 1'b0, 40);

    // Reset in the middle of a SAR run.
    wait_idle();
    vin = 8'd100;
    bus.mode = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (17) tick();
    rst_n = 1'b0;
    #1;
    check("midrun_reset_outputs", {bus.dac_code, bus.busy, bus.done, bus.result, bus.valid, bus.sat}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.done === 1'b1) ndone++;
      if (bus.busy === 1'b1) nbusy++;
    end
    check("midrun_reset_no_done", ndone, 0);
    check("midrun_reset_no_busy", nbusy, 0);
    $display("conv midrun_reset aborted done_pulses=%0d", ndone);
    run_conv("sar37_after_reset", 1'b0, 8'd37, -1, 8'd37, 1'b0, 40);

    // Back-to-back conversions with start held and a glitching comparator.
    async_mode = 1'b1;
    comp_async = (vin >= bus.dac_code);
    wait_idle();
    vin = 8'd200;
    bus.mode = 1'b0;
    bus.start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      tick();
      check($sformatf("b2b%0d_busy_up", b), bus.busy, 1);
      check($sformatf("b2b%0d_valid_clr", b), bus.valid, 0);
      n = 0;
      while (bus.done !== 1'b1 && n < BOUND) begin
        tick();
        n++;
      end
      check($sformatf("b2b%0d_latency", b), n, 40);
      check($sformatf("b2b%0d_result", b), bus.result, 200);
      check($sformatf("b2b%0d_valid", b), bus.valid, 1);
      $display("conv b2b%0d mode=0 vin=200 result=%0d cycles=%0d", b, bus.result, n);
      if (b == 2) bus.start = 1'b0;
      tick();
      check($sformatf("b2b%0d_idle", b), {bus.done, bus.busy, bus.valid}, 3'b001);
    end

    for (int r = 0; r < 16; r++) begin
      m = 1'($urandom_range(0, 1));
      v = 8'($urandom_range(0, 255));
      async_mode = 1'($urandom_range(0, 1));
      comp_async = (vin >= bus.dac_code);
      ref_model(m, v, r_res, r_sat, r_lat);
      run_conv($sformatf("rand%0d", r), m, v, -1, r_res, r_sat, r_lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
